// File: rtl/lego_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : lego_pkg
//  Purpose  : Shared types and helpers for the Lego systolic array feeders.
//             Provides the Lego configuration encoding, the feeder FSM state
//             encoding, lane/depth constants and skew-length helpers.
//  Revision : 1.0  initial release
// ============================================================================
package lego_pkg;

    localparam int LEGO_LANES      = 64;
    // Deepest skew is LEGO_LANES-1 register stages.
    localparam int LEGO_MAX_STAGES = LEGO_LANES - 1;
    localparam int LEGO_DEPTH_W    = 6;

    typedef enum logic [1:0] {
        LEGO_2X2  = 2'd0,
        LEGO_4IND = 2'd1,
        LEGO_4X1  = 2'd2,
        LEGO_RSVD = 2'd3
    } lego_mode_e;

    typedef enum logic [1:0] {
        FEED_IDLE   = 2'd0,
        FEED_STREAM = 2'd1,
        FEED_FLUSH  = 2'd2,
        FEED_DONE   = 2'd3
    } feed_state_e;

    // Skew group length L for a configuration; the reserved code behaves as 2x2.
    function automatic logic [6:0] lego_skew_len(input lego_mode_e mode);
        logic [6:0] len;
        case (mode)
            LEGO_4IND: len = 7'd16;
            LEGO_4X1:  len = 7'd64;
            default:   len = 7'd32;
        endcase
        return len;
    endfunction

    // L-1: since every L is a power of two this is also the lane-index mask
    // giving d_i = i mod L.
    function automatic logic [LEGO_DEPTH_W-1:0] lego_skew_mask(input lego_mode_e mode);
        return LEGO_DEPTH_W'(lego_skew_len(mode) - 7'd1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/lego_skew_lane.sv
`default_nettype none
// ============================================================================
//  Module   : lego_skew_lane
//  Purpose  : One lane of the activation skew: a 63-stage data+valid shift
//             register with a depth-selected tap. Depth 0 taps the lane input
//             directly so the caller's output register gives one cycle.
//  Ports    : clk, rst        - clock, synchronous active-high reset
//             clr             - drop every in-flight lane-valid bit
//             in_data/in_valid- stage-0 input (bubble = valid 0)
//             depth_load      - capture depth_in (tile start)
//             depth_in        - tap depth for the coming tile
//             tap_data/valid  - selected stage output (combinational)
//  Revision : 1.0  initial release
// ============================================================================
module lego_skew_lane
    import lego_pkg::*;
#(
    parameter int DATA_W = 8
)(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic [DATA_W-1:0]       in_data,
    input  logic                    in_valid,
    input  logic                    depth_load,
    input  logic [LEGO_DEPTH_W-1:0] depth_in,
    output logic [DATA_W-1:0]       tap_data,
    output logic                    tap_valid
);

    logic [DATA_W-1:0]          r_data_q [LEGO_MAX_STAGES];
    logic [DATA_W-1:0]          w_data_d [LEGO_MAX_STAGES];
    logic [LEGO_MAX_STAGES-1:0] r_valid_q;
    logic [LEGO_MAX_STAGES-1:0] w_valid_d;
    logic [LEGO_DEPTH_W-1:0]    r_depth_q;
    logic [LEGO_DEPTH_W-1:0]    w_depth_d;
    logic [LEGO_DEPTH_W-1:0]    w_tap_idx;

    always_comb begin
        w_data_d[0]  = in_data;
        w_valid_d[0] = in_valid & ~clr;
        for (int k = 1; k < LEGO_MAX_STAGES; k++) begin
            w_data_d[k]  = r_data_q[k-1];
            w_valid_d[k] = r_valid_q[k-1] & ~clr;
        end
        // The new depth must already steer the tap on the tile-start cycle,
        // otherwise a depth-0 lane would lose the first vector.
        w_depth_d = depth_load ? depth_in : r_depth_q;
        w_tap_idx = w_depth_d - LEGO_DEPTH_W'(1);
        if (w_depth_d == '0) begin
            tap_data  = in_data;
            tap_valid = in_valid;
        end else begin
            tap_data  = r_data_q[w_tap_idx];
            tap_valid = r_valid_q[w_tap_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid_q <= '0;
            r_depth_q <= '0;
            for (int k = 0; k < LEGO_MAX_STAGES; k++) begin
                r_data_q[k] <= '0;
            end
        end else begin
            r_valid_q <= w_valid_d;
            r_depth_q <= w_depth_d;
            for (int k = 0; k < LEGO_MAX_STAGES; k++) begin
                r_data_q[k] <= w_data_d[k];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/lego_act_feeder.sv
`default_nettype none
// ============================================================================
//  Module   : lego_act_feeder
//  Purpose  : Activation-side transmitter for the Lego systolic array. Takes
//             one 64-lane vector per cycle (valid/ready), skews lane i by
//             i mod L stages for the tile's configuration, registers the
//             result onto the array's left edge and flushes L-1 bubbles.
//  Ports    : clk, rst               - clock, synchronous active-high reset
//             mode                   - Lego configuration, sampled at tile start
//             in_vec/in_valid/in_last/in_ready - activation input handshake
//             act_out/act_valid      - array act_in / valid_in
//             done                   - pulse on the final drained element
//             mode_err               - reserved mode seen at last tile start
//  Revision : 1.0  initial release
// ============================================================================
module lego_act_feeder
    import lego_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int LANES  = LEGO_LANES
)(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [1:0]              mode,
    input  logic [DATA_W*LANES-1:0] in_vec,
    input  logic                    in_valid,
    input  logic                    in_last,
    output logic                    in_ready,
    output logic [DATA_W*LANES-1:0] act_out,
    output logic                    act_valid,
    output logic                    done,
    output logic                    mode_err
);

    feed_state_e             r_state_q, w_state_d;
    lego_mode_e              r_mode_q, w_mode_d, w_mode_eff;
    logic [LEGO_DEPTH_W-1:0] r_cnt_q, w_cnt_d;
    logic                    r_mode_err_q, w_mode_err_d;
    logic [DATA_W*LANES-1:0] r_act_q, w_act_d;
    logic [LANES-1:0]        r_lv_q, w_lv_d;

    logic                    w_ready;
    logic                    w_accept;
    logic                    w_start;
    logic                    w_clr;
    logic [LEGO_DEPTH_W-1:0] w_mask;
    logic [DATA_W*LANES-1:0] w_lane_in;
    logic [DATA_W*LANES-1:0] w_tap_data;
    logic [LANES-1:0]        w_tap_valid;
    logic                    w_all_active;

    assign w_ready  = (r_state_q == FEED_IDLE) || (r_state_q == FEED_STREAM);
    assign w_accept = in_valid & w_ready;
    assign w_start  = w_accept & (r_state_q == FEED_IDLE);
    // After the DONE cycle every lane has emitted its last element; wiping
    // the stages means a later tile with deeper taps never sees stale data.
    assign w_clr    = (r_state_q == FEED_DONE);

    // In IDLE the configuration comes straight from the port so the
    // tile-start vector is already skewed for the new mode.
    assign w_mode_eff   = (r_state_q == FEED_IDLE) ? lego_mode_e'(mode) : r_mode_q;
    assign w_mask       = lego_skew_mask(w_mode_eff);
    assign w_all_active = (w_mode_eff == LEGO_4IND) || (w_mode_eff == LEGO_4X1);
    assign w_lane_in    = w_accept ? in_vec : '0;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q    <= FEED_IDLE;
            r_mode_q     <= LEGO_2X2;
            r_cnt_q      <= '0;
            r_mode_err_q <= 1'b0;
        end else begin
            r_state_q    <= w_state_d;
            r_mode_q     <= w_mode_d;
            r_cnt_q      <= w_cnt_d;
            r_mode_err_q <= w_mode_err_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_d    = r_state_q;
        w_mode_d     = r_mode_q;
        w_cnt_d      = r_cnt_q;
        w_mode_err_d = r_mode_err_q;
        case (r_state_q)
            FEED_IDLE: begin
                if (w_accept) begin
                    w_mode_d     = lego_mode_e'(mode);
                    w_mode_err_d = (mode == LEGO_RSVD);
                    w_state_d    = in_last ? FEED_FLUSH : FEED_STREAM;
                end
            end
            FEED_STREAM: begin
                if (w_accept && in_last) begin
                    w_state_d = FEED_FLUSH;
                end
            end
            FEED_FLUSH: begin
                if (r_cnt_q == '0) begin
                    w_state_d = FEED_DONE;
                end else begin
                    w_cnt_d = r_cnt_q - LEGO_DEPTH_W'(1);
                end
            end
            default: begin
                w_state_d = FEED_IDLE;
            end
        endcase
        // FLUSH spans L-1 cycles, counted down from L-2 to 0.
        if (w_accept && in_last) begin
            w_cnt_d = w_mask - LEGO_DEPTH_W'(1);
        end
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        in_ready  = w_ready & ~rst;
        done      = (r_state_q == FEED_DONE);
        act_out   = r_act_q;
        act_valid = |r_lv_q;
        mode_err  = r_mode_err_q;
    end

    // ---------------- skew lanes ----------------
    generate
        for (genvar i = 0; i < LANES; i++) begin : g_lane
            localparam logic [LEGO_DEPTH_W-1:0] c_lane_idx = LEGO_DEPTH_W'(i);

            lego_skew_lane #(
                .DATA_W (DATA_W)
            ) u_lane (
                .clk        (clk),
                .rst        (rst),
                .clr        (w_clr),
                .in_data    (w_lane_in[i*DATA_W +: DATA_W]),
                .in_valid   (w_accept),
                .depth_load (w_start),
                .depth_in   (c_lane_idx & w_mask),
                .tap_data   (w_tap_data[i*DATA_W +: DATA_W]),
                .tap_valid  (w_tap_valid[i])
            );
        end
    endgenerate

    // ---------------- output register ----------------
    // Inactive lanes (upper half in 2x2/reserved) and bubbles drive zero.
    always_comb begin
        w_lv_d  = '0;
        w_act_d = '0;
        for (int i = 0; i < LANES; i++) begin
            w_lv_d[i] = w_tap_valid[i] & ((i < LANES/2) || w_all_active);
            w_act_d[i*DATA_W +: DATA_W] = w_lv_d[i] ? w_tap_data[i*DATA_W +: DATA_W] : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_act_q <= '0;
            r_lv_q  <= '0;
        end else begin
            r_act_q <= w_act_d;
            r_lv_q  <= w_lv_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lego_act_feeder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lego_act_feeder
//  Purpose  : Self-checking bench for lego_act_feeder. Each accepted vector
//             scatters its expected lane values into a per-cycle expectation
//             table and queues its done cycle; every cycle the outputs are
//             compared against the table.
//  Revision : 1.0  initial release
// ============================================================================
module tb_lego_act_feeder;

    localparam int DW   = 8;
    localparam int NL   = 64;
    localparam int VW   = DW * NL;
    localparam int HMAX = 4096;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [1:0]    mode = 2'd0;
    logic [VW-1:0] in_vec = '0;
    logic          in_valid = 1'b0;
    logic          in_last = 1'b0;
    logic          in_ready;
    logic [VW-1:0] act_out;
    logic          act_valid;
    logic          done;
    logic          mode_err;

    always #5 clk = ~clk;

    lego_act_feeder #(.DATA_W(DW), .LANES(NL)) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .in_vec    (in_vec),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .act_out   (act_out),
        .act_valid (act_valid),
        .done      (done),
        .mode_err  (mode_err)
    );

    int            total = 0;
    int            bad   = 0;
    int            cyc   = 0;
    logic [VW-1:0] exp_bus [HMAX];
    logic          exp_lv  [HMAX];
    int            done_q[$];
    int            last_t = -1000;
    int            last_l = 1;
    bit            in_tile = 1'b0;
    logic [1:0]    tile_mode = 2'd0;
    logic          exp_err = 1'b0;
    logic          err_nx  = 1'b0;

    function automatic int tb_len(input logic [1:0] m);
        if (m == 2'd1) return 16;
        if (m == 2'd2) return 64;
        return 32;
    endfunction

    function automatic logic [VW-1:0] fill(input logic [7:0] v);
        logic [VW-1:0] r;
        for (int i = 0; i < NL; i++) r[i*DW +: DW] = v;
        return r;
    endfunction

    function automatic logic [VW-1:0] pat(input int seed);
        logic [VW-1:0] r;
        for (int i = 0; i < NL; i++) r[i*DW +: DW] = 8'((seed * 7 + i * 13) | 1);
        return r;
    endfunction

    function automatic bit ready_now();
        return !rst && !(cyc > last_t && cyc <= last_t + last_l);
    endfunction

    task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, expv);
        end
    endtask

    task automatic tick();
        bit ed;
        @(posedge clk);
        #1;
        cyc++;
        exp_err = err_nx;
        ed = 1'b0;
        if (done_q.size() > 0) begin
            if (done_q[0] == cyc) begin
                ed = 1'b1;
                void'(done_q.pop_front());
            end
        end
        chk("act_out",   act_out,   exp_bus[cyc]);
        chk("act_valid", VW'(act_valid), VW'(exp_lv[cyc]));
        chk("done",      VW'(done),      VW'(ed));
        chk("in_ready",  VW'(in_ready),  VW'(ready_now()));
        chk("mode_err",  VW'(mode_err),  VW'(exp_err));
    endtask

    task automatic drive(input bit v, input bit l, input logic [VW-1:0] vec);
        int L;
        int c;
        in_valid = v;
        in_last  = l;
        in_vec   = vec;
        if (v && ready_now()) begin
            if (!in_tile) begin
                tile_mode = mode;
                err_nx    = (mode == 2'd3);
                in_tile   = 1'b1;
            end
            L = tb_len(tile_mode);
            for (int i = 0; i < NL; i++) begin
                if (i < 32 || tile_mode == 2'd1 || tile_mode == 2'd2) begin
                    c = cyc + 1 + (i % L);
                    exp_bus[c][i*DW +: DW] = vec[i*DW +: DW];
                    exp_lv[c] = 1'b1;
                end
            end
            if (l) begin
                in_tile = 1'b0;
                last_t  = cyc;
                last_l  = L;
                done_q.push_back(cyc + L);
            end
        end
        tick();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(1'b0, 1'b0, '0);
    endtask

    task automatic do_reset(input int n);
        rst      = 1'b1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        for (int c = cyc + 1; c < cyc + 80; c++) begin
            exp_bus[c] = '0;
            exp_lv[c]  = 1'b0;
        end
        done_q.delete();
        err_nx  = 1'b0;
        in_tile = 1'b0;
        last_t  = -1000;
        for (int k = 0; k < n; k++) tick();
        rst = 1'b0;
        #1;
        chk("ready_after_rst", VW'(in_ready), VW'(1'b1));
    endtask

    initial begin
        int t;
        logic [VW-1:0] pv;
        for (int c = 0; c < HMAX; c++) begin
            exp_bus[c] = '0;
            exp_lv[c]  = 1'b0;
        end

        // Reset state
        do_reset(3);

        // Mode 1: four vectors valued 1..4, last on the 4th
        mode = 2'd1;
        drive(1'b1, 1'b0, fill(8'd1));
        drive(1'b1, 1'b0, fill(8'd2));
        drive(1'b1, 1'b0, fill(8'd3));
        t = cyc;
        drive(1'b1, 1'b1, fill(8'd4));
        for (int k = 0; k < 20; k++) begin
            drive(1'b0, 1'b0, '0);
            if (cyc == t + 1)  chk("m1_lane0_last", VW'(act_out[0*DW +: DW]), VW'(8'd4));
            if (cyc == t + 13) chk("m1_lane15_v1", VW'(act_out[15*DW +: DW]), VW'(8'd1));
            if (cyc == t + 16) chk("m1_done", VW'(done), VW'(1'b1));
        end

        // Mode 0: single vector with last, mode change during the tile ignored
        mode = 2'd0;
        t = cyc;
        drive(1'b1, 1'b1, fill(8'hA5));
        mode = 2'd2;
        for (int k = 0; k < 40; k++) begin
            drive(1'b0, 1'b0, '0);
            chk("m0_upper_zero", VW'(act_out[VW-1:VW/2]), '0);
            if (cyc == t + 32) begin
                chk("m0_lane31", VW'(act_out[31*DW +: DW]), VW'(8'hA5));
                chk("m0_done", VW'(done), VW'(1'b1));
            end
        end

        // Mode 2 with a one-cycle in_valid gap
        mode = 2'd2;
        t = cyc;
        drive(1'b1, 1'b0, pat(3));
        drive(1'b0, 1'b0, '0);
        drive(1'b1, 1'b1, pat(4));
        for (int k = 0; k < 70; k++) begin
            drive(1'b0, 1'b0, '0);
            if (cyc == t + 64) begin
                pv = pat(3);
                chk("m2_lane63_a", VW'(act_out[63*DW +: DW]), VW'(pv[63*DW +: DW]));
            end
            if (cyc == t + 65) chk("m2_lane63_gap", VW'(act_out[63*DW +: DW]), '0);
            if (cyc == t + 66) begin
                pv = pat(4);
                chk("m2_lane63_b", VW'(act_out[63*DW +: DW]), VW'(pv[63*DW +: DW]));
            end
        end

        // Reserved mode behaves as 2x2 and flags mode_err; next tile clears it
        mode = 2'd3;
        drive(1'b1, 1'b0, pat(5));
        drive(1'b1, 1'b1, pat(6));
        idle(40);
        mode = 2'd1;
        drive(1'b1, 1'b1, pat(7));
        idle(20);

        // Reset during FLUSH: all in-flight data discarded, no done
        mode = 2'd2;
        drive(1'b1, 1'b0, pat(8));
        drive(1'b1, 1'b1, pat(9));
        idle(5);
        do_reset(1);
        idle(70);

        // in_valid held through FLUSH/DONE: nothing accepted until IDLE
        mode = 2'd1;
        drive(1'b1, 1'b0, pat(10));
        drive(1'b1, 1'b1, pat(11));
        for (int k = 0; k < 25; k++) drive(1'b1, 1'b0, pat(12 + k));
        drive(1'b1, 1'b1, pat(40));
        idle(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lego_act_feeder.md
# lego_act_feeder

Activation-side transmitter for the Lego systolic array. It accepts one 64-lane activation vector per cycle from the activation buffer over a valid/ready handshake and applies the per-lane diagonal skew required by the selected Lego configuration. It drives the array's left-edge activation bus and its valid strobe, then appends a zero flush so the deepest lane drains. It sits between the activation SRAM read path and the array's `act_in`/`valid_in` inputs.

## Interface
Parameters:
- `DATA_W`, 8, activation element width
- `LANES`, 64, number of left-edge lanes, fixed to 64 for this array

Ports:
- `clk`  in  1  single clock
- `rst`  in  1  reset, synchronous, active-high
- `mode`  in  2  Lego configuration, `TYPE_Lego` encoding; sampled only on the tile-start accept
- `in_vec`  in  `DATA_W` x `LANES`  activation vector; lane i feeds array row i
- `in_valid`  in  1  `in_vec` is valid
- `in_last`  in  1  marks the final vector of a tile; qualified by `in_valid`
- `in_ready`  out  1  feeder accepts `in_vec` this cycle
- `act_out`  out  `DATA_W` x `LANES`  skewed activations, connects to array `act_in`
- `act_valid`  out  1  connects to array `valid_in`
- `done`  out  1  one-cycle pulse on the final drained element of a tile
- `mode_err`  out  1  sticky; reserved `mode` sampled at tile start

## Operation
- Skew group length L per mode:
  - mode 0 (2x2, 32 rows): L=32; lanes 0–31 active; lanes 32–63 forced to 0
  - mode 1 (4 independent tiles): L=16; all lanes active
  - mode 2 (4x1 chain): L=64; all lanes active
  - mode 3: reserved; behaves as mode 0 and sets `mode_err`
- Lane i delay is d_i = i mod L register stages, followed by one output register. Each stage carries data plus a lane-valid bit.
- States: IDLE, STREAM, FLUSH, DONE.
  - IDLE: `in_ready`=1. An accept latches `mode`, recomputes `mode_err`, and moves to STREAM. If `in_last` is also set, it moves directly to FLUSH.
  - STREAM: `in_ready`=1. When `in_valid`=0, a bubble (data 0, lane-valid 0) enters every lane and the pipeline keeps advancing; the array has no backpressure. An accept with `in_last` moves to FLUSH.
  - FLUSH: `in_ready`=0. Bubbles enter the pipeline. Lasts exactly L-1 cycles, then moves to DONE. For L=1 the state would be skipped, but no mode has L=1.
  - DONE: `in_ready`=0, `done`=1 for one cycle, then back to IDLE.
- Lanes whose output lane-valid is 0 drive 0 on `act_out`.
- `act_valid` = OR of the output lane-valid bits of the active lanes.
- Data passes through with no arithmetic and no width change.

## Timing
- A vector accepted at cycle t appears on lane i of `act_out` at cycle t+1+d_i.
- Last vector accepted at cycle T: FLUSH covers T+1..T+L-1. DONE and `done`=1 occur at T+L, the same cycle the top lane's final element is on `act_out`.
- Minimum tile-to-tile gap: the next accept can occur at T+L+1, the IDLE cycle.
- Reset values: `act_out`=0, `act_valid`=0, `done`=0, `mode_err`=0, `in_ready`=0 during reset and 1 in the first cycle after reset; state IDLE. All skew stages clear.
- Reset mid-tile takes effect on the next edge, discards all in-flight data, and issues no `done`.
- `mode` changes outside the tile-start accept are ignored.

## Structure
- Shared package `lego_pkg`:
  - `lego_mode_e` enum: `LEGO_2X2`=0, `LEGO_4IND`=1, `LEGO_4X1`=2, `LEGO_RSVD`=3
  - `LEGO_LANES`=64
  - function `lego_skew_len(mode)` returning L
  - feeder state enum
- Sub-module `lego_skew_lane`: one lane of a max-depth (63-stage) data+valid shift register. The tap is selected by a registered depth input, which is held constant while a tile is in flight. Generate 64 instances.
- The FSM and output register live in the top level.

## Test plan
- Mode 1, reset then 4 vectors with in_vec[i]=k for vector k=1..4, last on the 4th at T → lane 0 shows 1..4 at T-2..T+1; lane 15 shows vector 1 (value 1) at T-3+16 = T+13; `done` at T+16.
- Mode 0, single vector with `in_last` on the first accept at cycle t, value 0xA5 on all lanes → lane 31 outputs 0xA5 at t+32; lanes 32–63 stay 0 throughout; `done` at t+32.
- Mode 2 with an `in_valid` gap: accepts at cycles t, t+2 → lane 63 `act_out` nonzero only at t+64 and t+66; `act_valid` is 0 at cycle t+1 only while no lane carries data.
- mode=3 at start → `mode_err`=1, behaviour identical to mode 0; next tile with mode=1 → `mode_err` returns to 0.
- Reset asserted during FLUSH → next cycle all outputs 0; no `done`; `in_ready`=1 after reset release.
- `in_valid` held during FLUSH/DONE → `in_ready`=0, and no vector is accepted until IDLE.
